// File: rtl/lsu_pkg.sv
// Shared types and the sub-word store merge helper for the load/store unit.
package lsu_pkg;

    localparam int LSU_DATA_W    = 32;
    localparam int LSU_MEM_WORDS = 6501;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    // Replace the addressed byte/half lane of a memory word; word and reserved sizes overwrite it all.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] merged;
        merged = word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/load_store_unit_extract.sv
// Load lane selection with sign/zero extension (little-endian lanes).
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory; sub-word stores
// take a read-modify-write with one stall cycle. Define LSU_ALIGN_CHECK_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misalign_err,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state_q, state_d;
    logic [DATA_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] merge_word_q, merge_word_d;
    logic [DATA_W-1:0] extracted;
    logic              sub_word;
    logic              misaligned;

    load_extract u_load_extract (
        .word        (mem_read_data),
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .data        (extracted)
    );

    assign sub_word = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = (req_read || req_write) &&
                        (((req_size == SZ_HALF) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_addr_q   <= '0;
            merge_word_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_addr_q   <= lat_addr_d;
            merge_word_q <= merge_word_d;
        end
    end

    // A store beats a simultaneous load, and the second RMW cycle ignores the request inputs.
    always_comb begin
        state_d        = state_q;
        lat_addr_d     = lat_addr_q;
        merge_word_d   = merge_word_q;
        mem_address    = req_addr >> 2;
        mem_write_data = req_wdata;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        stall          = 1'b0;
        load_data      = '0;
        misalign_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (misaligned) begin
                        misalign_err = 1'b1;
                    end else if (req_write) begin
                        if (sub_word) begin
                            mem_read     = 1'b1;
                            stall        = 1'b1;
                            merge_word_d = lane_merge(mem_read_data, req_addr[1:0], req_size, req_wdata);
                            lat_addr_d   = req_addr;
                            state_d      = RMW_WR;
                        end else begin
                            mem_write = 1'b1;
                        end
                    end else if (req_read) begin
                        mem_read  = 1'b1;
                        load_data = extracted;
                    end
                end
                RMW_WR: begin
                    mem_address    = lat_addr_q >> 2;
                    mem_write      = 1'b1;
                    mem_write_data = merge_word_q;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
